// File: rtl/regfile_sequencer.sv
// Arbitrates two requesters onto an edge-strobed register file, issuing one-cycle x/y/z strobes and a response pulse.
// Define REGSEQ_ROUND_ROBIN_EN for round-robin arbitration; the default build gives port A fixed priority.
module regfile_sequencer #(
  parameter int B   = 8,
  parameter int N_B = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic           a_rd_x,
  input  logic           a_rd_y,
  input  logic           a_wr,
  input  logic [N_B-1:0] a_x_sel,
  input  logic [N_B-1:0] a_y_sel,
  input  logic [N_B-1:0] a_z_sel,
  input  logic [B-1:0]   a_z_data,
  input  logic           b_valid,
  output logic           b_ready,
  input  logic           b_rd_x,
  input  logic           b_rd_y,
  input  logic           b_wr,
  input  logic [N_B-1:0] b_x_sel,
  input  logic [N_B-1:0] b_y_sel,
  input  logic [N_B-1:0] b_z_sel,
  input  logic [B-1:0]   b_z_data,
  output logic           rsp_valid,
  output logic           rsp_port,
  output logic [B-1:0]   rsp_x,
  output logic [B-1:0]   rsp_y,
  output logic           rf_x_enb,
  output logic           rf_y_enb,
  output logic           rf_z_enb,
  output logic [N_B-1:0] rf_x_sel,
  output logic [N_B-1:0] rf_y_sel,
  output logic [N_B-1:0] rf_z_sel,
  output logic [B-1:0]   rf_z_in,
  input  logic [B-1:0]   rf_x_out,
  input  logic [B-1:0]   rf_y_out
);

  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR_HI, WR_LO, RSP} state_e;

  typedef struct packed {
    logic           rd_x;
    logic           rd_y;
    logic           wr;
    logic [N_B-1:0] x_sel;
    logic [N_B-1:0] y_sel;
    logic [N_B-1:0] z_sel;
    logic [B-1:0]   z_data;
  } req_t;

  state_e         state_q, state_d;
  logic           rd_x_q, rd_x_d, rd_y_q, rd_y_d, wr_q, wr_d, port_q, port_d;
  logic           rf_x_enb_q, rf_x_enb_d, rf_y_enb_q, rf_y_enb_d, rf_z_enb_q, rf_z_enb_d;
  logic [N_B-1:0] rf_x_sel_q, rf_x_sel_d, rf_y_sel_q, rf_y_sel_d, rf_z_sel_q, rf_z_sel_d;
  logic [B-1:0]   rf_z_in_q, rf_z_in_d, rsp_x_q, rsp_x_d, rsp_y_q, rsp_y_d;

  logic grant_a, grant_b, idle_ok, accept;
  req_t a_req, b_req, req;

  assign a_req = {a_rd_x, a_rd_y, a_wr, a_x_sel, a_y_sel, a_z_sel, a_z_data};
  assign b_req = {b_rd_x, b_rd_y, b_wr, b_x_sel, b_y_sel, b_z_sel, b_z_data};

`ifdef REGSEQ_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // ptr_q = 1 means B wins a tie; after an accept the other port gets the next tie.
  assign grant_a = a_valid && (!b_valid || !ptr_q);
  assign grant_b = b_valid && (!a_valid || ptr_q);
  assign ptr_d   = accept ? grant_a : ptr_q;

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end
`else
  assign grant_a = a_valid;
  assign grant_b = b_valid && !a_valid;
`endif

  assign idle_ok = (state_q == IDLE) && !reset;
  assign a_ready = idle_ok && grant_a;
  assign b_ready = idle_ok && grant_b;
  assign accept  = a_ready || b_ready;
  assign req     = grant_b ? b_req : a_req;

  // Strobes are computed one state ahead so every rf_* output comes straight from a flop.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    wr_d       = wr_q;
    port_d     = port_q;
    rf_x_sel_d = rf_x_sel_q;
    rf_y_sel_d = rf_y_sel_q;
    rf_z_sel_d = rf_z_sel_q;
    rf_z_in_d  = rf_z_in_q;
    rsp_x_d    = rsp_x_q;
    rsp_y_d    = rsp_y_q;
    rf_x_enb_d = 1'b0;
    rf_y_enb_d = 1'b0;
    rf_z_enb_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          rd_x_d     = req.rd_x;
          rd_y_d     = req.rd_y;
          wr_d       = req.wr;
          port_d     = grant_b;
          rf_x_sel_d = req.x_sel;
          rf_y_sel_d = req.y_sel;
          rf_z_sel_d = req.z_sel;
          rf_z_in_d  = req.z_data;
          if (req.rd_x || req.rd_y) begin
            state_d    = RD_HI;
            rf_x_enb_d = req.rd_x;
            rf_y_enb_d = req.rd_y;
          end else if (req.wr) begin
            state_d    = WR_HI;
            rf_z_enb_d = 1'b1;
          end else begin
            state_d = RSP;
          end
        end
      end
      RD_HI: state_d = RD_LO;
      RD_LO: begin
        if (rd_x_q) rsp_x_d = rf_x_out;
        if (rd_y_q) rsp_y_d = rf_y_out;
        if (wr_q) begin
          state_d    = WR_HI;
          rf_z_enb_d = 1'b1;
        end else begin
          state_d = RSP;
        end
      end
      WR_HI:   state_d = WR_LO;
      WR_LO:   state_d = RSP;
      RSP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q    <= IDLE;
      rd_x_q     <= 1'b0;
      rd_y_q     <= 1'b0;
      wr_q       <= 1'b0;
      port_q     <= 1'b0;
      rf_x_enb_q <= 1'b0;
      rf_y_enb_q <= 1'b0;
      rf_z_enb_q <= 1'b0;
      rf_x_sel_q <= '0;
      rf_y_sel_q <= '0;
      rf_z_sel_q <= '0;
      rf_z_in_q  <= '0;
      rsp_x_q    <= '0;
      rsp_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      wr_q       <= wr_d;
      port_q     <= port_d;
      rf_x_enb_q <= rf_x_enb_d;
      rf_y_enb_q <= rf_y_enb_d;
      rf_z_enb_q <= rf_z_enb_d;
      rf_x_sel_q <= rf_x_sel_d;
      rf_y_sel_q <= rf_y_sel_d;
      rf_z_sel_q <= rf_z_sel_d;
      rf_z_in_q  <= rf_z_in_d;
      rsp_x_q    <= rsp_x_d;
      rsp_y_q    <= rsp_y_d;
    end
  end

  assign rsp_valid = (state_q == RSP);
  assign rsp_port  = port_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;
  assign rf_x_enb  = rf_x_enb_q;
  assign rf_y_enb  = rf_y_enb_q;
  assign rf_z_enb  = rf_z_enb_q;
  assign rf_x_sel  = rf_x_sel_q;
  assign rf_y_sel  = rf_y_sel_q;
  assign rf_z_sel  = rf_z_sel_q;
  assign rf_z_in   = rf_z_in_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: edge-strobed register file model, transaction-level reference, directed tests.
// Honours REGSEQ_ROUND_ROBIN_EN the same way the design does.
module tb_regfile_sequencer;
  localparam int B   = 8;
  localparam int N_B = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           a_valid = 1'b0, a_rd_x = 1'b0, a_rd_y = 1'b0, a_wr = 1'b0;
  logic [N_B-1:0] a_x_sel = '0, a_y_sel = '0, a_z_sel = '0;
  logic [B-1:0]   a_z_data = '0;
  logic           b_valid = 1'b0, b_rd_x = 1'b0, b_rd_y = 1'b0, b_wr = 1'b0;
  logic [N_B-1:0] b_x_sel = '0, b_y_sel = '0, b_z_sel = '0;
  logic [B-1:0]   b_z_data = '0;
  logic           a_ready, b_ready, rsp_valid, rsp_port;
  logic [B-1:0]   rsp_x, rsp_y, rf_z_in;
  logic           rf_x_enb, rf_y_enb, rf_z_enb;
  logic [N_B-1:0] rf_x_sel, rf_y_sel, rf_z_sel;
  logic [B-1:0]   rf_x_out = '0, rf_y_out = '0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [B-1:0] rf_mem [16] = '{8'h80, 8'h81, 8'h07, 8'h11, 8'h84, 8'h22, 8'h86, 8'h87,
                                8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F};
  logic [B-1:0] ref_mem [16] = '{8'h80, 8'h81, 8'h07, 8'h11, 8'h84, 8'h22, 8'h86, 8'h87,
                                 8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F};

  regfile_sequencer #(.B(B), .N_B(N_B)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd_x(a_rd_x), .a_rd_y(a_rd_y), .a_wr(a_wr),
    .a_x_sel(a_x_sel), .a_y_sel(a_y_sel), .a_z_sel(a_z_sel), .a_z_data(a_z_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd_x(b_rd_x), .b_rd_y(b_rd_y), .b_wr(b_wr),
    .b_x_sel(b_x_sel), .b_y_sel(b_y_sel), .b_z_sel(b_z_sel), .b_z_data(b_z_data),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_x(rsp_x), .rsp_y(rsp_y),
    .rf_x_enb(rf_x_enb), .rf_y_enb(rf_y_enb), .rf_z_enb(rf_z_enb),
    .rf_x_sel(rf_x_sel), .rf_y_sel(rf_y_sel), .rf_z_sel(rf_z_sel), .rf_z_in(rf_z_in),
    .rf_x_out(rf_x_out), .rf_y_out(rf_y_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Register file reacts only to rising strobe edges.
  always @(posedge rf_x_enb) rf_x_out <= rf_mem[rf_x_sel];
  always @(posedge rf_y_enb) rf_y_out <= rf_mem[rf_y_sel];
  always @(posedge rf_z_enb) rf_mem[rf_z_sel] <= rf_z_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns {b_grant, a_grant} for the given request pattern.
  function automatic logic [1:0] exp_grant(input logic av, input logic bv, input logic ptr);
`ifdef REGSEQ_ROUND_ROBIN_EN
    if (av && bv) return ptr ? 2'b10 : 2'b01;
`endif
    if (av) return 2'b01;
    if (bv) return 2'b10;
    return {1'b0, ptr & 1'b0};
  endfunction

  // Reference model and per-cycle compare.
  initial begin
    int c, busy_until, x_cyc, y_cyc, z_cyc, rsp_cyc, sel_cyc;
    logic [N_B-1:0] m_xs, m_ys, m_zs, p_xs, p_ys, p_zs, prev_xs, prev_ys, prev_zs;
    logic [B-1:0] m_zin, p_zin, m_rx, m_ry;
    logic m_port, m_ptr, s1, s2, r1, r2, rx, ry, w, started;
    logic [1:0] g;
    busy_until = 0; x_cyc = -1; y_cyc = -1; z_cyc = -1; rsp_cyc = -1; sel_cyc = -1;
    m_xs = '0; m_ys = '0; m_zs = '0; p_xs = '0; p_ys = '0; p_zs = '0; m_zin = '0; p_zin = '0;
    prev_xs = '0; prev_ys = '0; prev_zs = '0; m_rx = '0; m_ry = '0; m_port = 1'b0; m_ptr = 1'b0;
    s1 = 1'b0; s2 = 1'b0; r1 = 1'b1; r2 = 1'b1; started = 1'b0;
    forever begin
      @(negedge clock);
      c = cyc;
      if (started) begin
        if (c == sel_cyc) begin
          m_xs = p_xs; m_ys = p_ys; m_zs = p_zs; m_zin = p_zin;
        end
        check("mon_x_enb", rf_x_enb, c == x_cyc);
        check("mon_y_enb", rf_y_enb, c == y_cyc);
        check("mon_z_enb", rf_z_enb, c == z_cyc);
        check("mon_rsp_valid", rsp_valid, c == rsp_cyc);
        if (c == rsp_cyc) begin
          check("mon_rsp_port", rsp_port, m_port);
          check("mon_rsp_x", rsp_x, m_rx);
          check("mon_rsp_y", rsp_y, m_ry);
        end
        check("mon_sels", {rf_x_sel, rf_y_sel, rf_z_sel, rf_z_in}, {m_xs, m_ys, m_zs, m_zin});
        g = (!reset && c > busy_until) ? exp_grant(a_valid, b_valid, m_ptr) : 2'b00;
        check("mon_ready", {b_ready, a_ready}, g);
        if ((s1 || s2) && !r1 && !r2)
          check("mon_sel_stable", {rf_x_sel, rf_y_sel, rf_z_sel}, {prev_xs, prev_ys, prev_zs});
        if (c == z_cyc) ref_mem[m_zs] = m_zin;
      end
      if (reset) begin
        started = 1'b1;
        if (x_cyc > c) x_cyc = -1;
        if (y_cyc > c) y_cyc = -1;
        if (z_cyc > c) z_cyc = -1;
        if (rsp_cyc > c) rsp_cyc = -1;
        busy_until = c;
        p_xs = '0; p_ys = '0; p_zs = '0; p_zin = '0; sel_cyc = c + 1;
        m_rx = '0; m_ry = '0; m_ptr = 1'b0; m_port = 1'b0;
      end else if (started && c > busy_until) begin
        g = exp_grant(a_valid, b_valid, m_ptr);
        if (g != 2'b00) begin
          m_port = g[1];
          m_ptr  = g[0];
          rx = m_port ? b_rd_x : a_rd_x;
          ry = m_port ? b_rd_y : a_rd_y;
          w  = m_port ? b_wr : a_wr;
          p_xs  = m_port ? b_x_sel : a_x_sel;
          p_ys  = m_port ? b_y_sel : a_y_sel;
          p_zs  = m_port ? b_z_sel : a_z_sel;
          p_zin = m_port ? b_z_data : a_z_data;
          sel_cyc = c + 1;
          x_cyc = rx ? c + 1 : -1;
          y_cyc = ry ? c + 1 : -1;
          if (rx) m_rx = ref_mem[p_xs];
          if (ry) m_ry = ref_mem[p_ys];
          if (rx || ry) begin
            z_cyc   = w ? c + 3 : -1;
            rsp_cyc = w ? c + 5 : c + 3;
          end else begin
            z_cyc   = w ? c + 1 : -1;
            rsp_cyc = w ? c + 3 : c + 1;
          end
          busy_until = rsp_cyc;
        end
      end
      s2 = s1; s1 = rf_x_enb | rf_y_enb | rf_z_enb;
      r2 = r1; r1 = reset;
      prev_xs = rf_x_sel; prev_ys = rf_y_sel; prev_zs = rf_z_sel;
    end
  end

  task automatic do_reset(input int n);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (n) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input logic port, input logic rx, input logic ry, input logic w,
                       input logic [N_B-1:0] xs, input logic [N_B-1:0] ys,
                       input logic [N_B-1:0] zs, input logic [B-1:0] zd);
    if (!port) begin
      a_rd_x = rx; a_rd_y = ry; a_wr = w; a_x_sel = xs; a_y_sel = ys; a_z_sel = zs; a_z_data = zd;
      a_valid = 1'b1;
    end else begin
      b_rd_x = rx; b_rd_y = ry; b_wr = w; b_x_sel = xs; b_y_sel = ys; b_z_sel = zs; b_z_data = zd;
      b_valid = 1'b1;
    end
  endtask

  // Issues one operation and waits (bounded) for its response; lat = -1 on timeout.
  task automatic issue(input logic port, input logic rx, input logic ry, input logic w,
                       input logic [N_B-1:0] xs, input logic [N_B-1:0] ys,
                       input logic [N_B-1:0] zs, input logic [B-1:0] zd,
                       output int lat, output logic [B-1:0] ox, output logic [B-1:0] oy,
                       output logic oport);
    int t_acc;
    bit got;
    lat = -1; ox = '0; oy = '0; oport = 1'b0; t_acc = 0;
    @(posedge clock); #1;
    drive(port, rx, ry, w, xs, ys, zs, zd);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      if (port ? b_ready : a_ready) begin got = 1; t_acc = cyc; end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clock); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (rsp_valid) begin got = 1; lat = cyc - t_acc; ox = rsp_x; oy = rsp_y; oport = rsp_port; end
    end
  endtask

  initial begin
    int lat;
    logic [B-1:0] ox, oy, exp_y9;
    logic op;
    logic [3:0] order, exp_order;
    bit got;
    order = '0;

    // Ready must stay low while reset is held, even with a request pending.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
    repeat (3) @(negedge clock);
    check("ready_in_reset", a_ready, 1'b0);
    a_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("reset_rsp", {rsp_valid, rsp_port, rsp_x, rsp_y}, '0);
    check("reset_rf", {rf_x_enb, rf_y_enb, rf_z_enb, rf_x_sel, rf_y_sel, rf_z_sel, rf_z_in}, '0);

    issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 8'h00, lat, ox, oy, op);
    check("rd_xy_lat", lat, 3);
    check("rd_xy_data", {op, ox, oy}, {1'b0, 8'h11, 8'h22});

    issue(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 4'd2, 8'h5A, lat, ox, oy, op);
    check("rdwr_lat", lat, 5);
    check("rdwr_old_value", ox, 8'h07);

    issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd0, 4'd0, 8'h00, lat, ox, oy, op);
    check("reread_value", ox, 8'h5A);
    check("unrequested_y_held", oy, 8'h22);

    issue(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 8'h3C, lat, ox, oy, op);
    check("wr_only_lat", lat, 3);

    issue(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 8'hFF, lat, ox, oy, op);
    check("null_lat", lat, 1);
    check("null_port", op, 1'b1);

    // Both ports request writes continuously.
    do_reset(2);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 8'hA9);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd10, 8'hBA);
    for (int k = 0; k < 4; k++) begin
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clock);
        if (a_ready || b_ready) begin got = 1; order[k] = b_ready; end
      end
      if (!got) check("grant_timeout", 0, 1);
      @(posedge clock);
    end
    #1 a_valid = 1'b0; b_valid = 1'b0;
`ifdef REGSEQ_ROUND_ROBIN_EN
    exp_order = 4'b1010;
    exp_y9 = 8'hBA;
`else
    exp_order = 4'b0000;
    exp_y9 = 8'h8A;
`endif
    check("grant_order", order, exp_order);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd10, 4'd0, 8'h00, lat, ox, oy, op);
    check("arb_writes", {ox, oy}, {8'hA9, exp_y9});

    // Reset lands in the RD_HI cycle of a read.
    @(posedge clock); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 8'h00);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (a_ready) got = 1;
    end
    if (!got) check("abort_accept_timeout", 0, 1);
    @(posedge clock); #1;
    a_valid = 1'b0; reset = 1'b1;
    @(negedge clock);
    check("abort_rd_hi_strobe", {rf_x_enb, rf_y_enb}, 2'b11);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("abort_enables_low", {rf_x_enb, rf_y_enb, rf_z_enb, rsp_valid}, 4'b0000);
    repeat (4) @(negedge clock);
    check("abort_no_rsp", rsp_valid, 1'b0);
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00);
    @(negedge clock);
    check("ready_after_reset", a_ready, 1'b1);
    @(posedge clock); #1 a_valid = 1'b0;
    repeat (3) @(negedge clock);

    issue(1'b1, 1'b1, 1'b1, 1'b1, 4'd7, 4'd2, 4'd7, 8'hC3, lat, ox, oy, op);
    check("b_rdwr_lat", lat, 5);
    check("b_rdwr_data", {op, ox, oy}, {1'b1, 8'h3C, 8'h5A});
    issue(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 4'd0, 8'h00, lat, ox, oy, op);
    check("b_reread", ox, 8'hC3);

    repeat (5) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

endmodule
